// File: rtl/hpm_event_ctrl.sv
// mhpmevent CSR bank, registered event steering and LCOFIP tracking for the HPM counters.
// Optional privilege-mode inhibit bits (MINH/SINH/UINH) enabled by HPM_PRIV_FILTER_EN.
module hpm_event_ctrl #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned COUNTERS   = 32,
  parameter int unsigned NUM_EVENTS = 32,
  parameter int unsigned SEL_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CSRMWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  input  logic [1:0]            PrivilegeModeW,
  input  logic [NUM_EVENTS-1:0] EventSrcM,
  input  logic                  InstrRetiredM,
  input  logic [COUNTERS-1:0]   CounterWrapM,
  input  logic [31:0]           MCOUNTINHIBIT_REGW,
  input  logic                  LCOFIClrM,
  output logic [COUNTERS-1:0]   CounterEventM,
  output logic [XLEN-1:0]       EventReadValM,
  output logic                  EventCSRHitM,
  output logic                  LCOFIPendingM
);

  localparam int unsigned SRC_W    = 2 ** SEL_W;
  localparam int unsigned OF_BIT   = XLEN - 1;
  localparam int unsigned MINH_BIT = XLEN - 2;
  localparam int unsigned SINH_BIT = XLEN - 3;
  localparam int unsigned UINH_BIT = XLEN - 4;
  localparam logic [COUNTERS-1:0] PROG_MASK = ~COUNTERS'(7);

  logic [SEL_W-1:0]    sel_q [COUNTERS];
  logic [SEL_W-1:0]    sel_d [COUNTERS];
  logic [COUNTERS-1:0] of_q, of_d;
  logic [COUNTERS-1:0] ev_d;
  logic [COUNTERS-1:0] privinh;
  logic [SRC_W-1:0]    src_pad;
  logic [4:0]          idx;
  logic                idx_ok, lo_hit, hi_hit, flag_hit;
  logic                sel_wr, flag_wr, lcof_d;

  // Address decode: low CSRs at 0x320+N, high halves at 0x720+N on RV32 only
  assign idx      = CSRAdrM[4:0];
  assign idx_ok   = (idx >= 5'd3) && (32'(idx) < COUNTERS);
  assign lo_hit   = idx_ok && (CSRAdrM[11:5] == 7'h19);
  assign hi_hit   = (XLEN == 32) && idx_ok && (CSRAdrM[11:5] == 7'h39);
  assign flag_hit = (XLEN == 32) ? hi_hit : lo_hit;
  assign sel_wr   = CSRMWriteM && lo_hit;
  assign flag_wr  = CSRMWriteM && flag_hit;

  assign EventCSRHitM = lo_hit || hi_hit;

  // Sources beyond NUM_EVENTS read as zero, so out-of-range SEL counts nothing
  assign src_pad = SRC_W'(EventSrcM);

`ifdef HPM_PRIV_FILTER_EN
  logic [COUNTERS-1:0] minh_q, sinh_q, uinh_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      minh_q <= '0;
      sinh_q <= '0;
      uinh_q <= '0;
    end else begin
      for (int unsigned i = 3; i < COUNTERS; i++) begin
        if (flag_wr && (32'(idx) == i)) begin
          minh_q[i] <= CSRWriteValM[MINH_BIT];
          sinh_q[i] <= CSRWriteValM[SINH_BIT];
          uinh_q[i] <= CSRWriteValM[UINH_BIT];
        end
      end
    end
  end

  assign privinh = ({COUNTERS{PrivilegeModeW == 2'b11}} & minh_q)
                 | ({COUNTERS{PrivilegeModeW == 2'b01}} & sinh_q)
                 | ({COUNTERS{PrivilegeModeW == 2'b00}} & uinh_q);
`else
  assign privinh = '0;
`endif

  // Next-state for SEL/OF, event enables and LCOFIP
  always_comb begin
    sel_d  = sel_q;
    of_d   = of_q;
    ev_d   = '0;
    lcof_d = (LCOFIPendingM && !LCOFIClrM) || (|(CounterWrapM & ~of_q & PROG_MASK));
    ev_d[0] = ~MCOUNTINHIBIT_REGW[0];
    ev_d[2] = InstrRetiredM & ~MCOUNTINHIBIT_REGW[2];
    for (int unsigned i = 3; i < COUNTERS; i++) begin
      if (sel_wr && (32'(idx) == i)) sel_d[i] = CSRWriteValM[SEL_W-1:0];
      if (flag_wr && (32'(idx) == i)) of_d[i] = CSRWriteValM[OF_BIT];
      of_d[i] = of_d[i] | CounterWrapM[i];
      ev_d[i] = src_pad[sel_q[i]] & (sel_q[i] != '0)
              & ~MCOUNTINHIBIT_REGW[i] & ~privinh[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < COUNTERS; i++) sel_q[i] <= '0;
      of_q          <= '0;
      CounterEventM <= '0;
      LCOFIPendingM <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      of_q          <= of_d;
      CounterEventM <= ev_d;
      LCOFIPendingM <= lcof_d;
    end
  end

  // Read mux from current state; same-cycle writes are not visible
  always_comb begin
    EventReadValM = '0;
    for (int unsigned i = 3; i < COUNTERS; i++) begin
      if (lo_hit && (32'(idx) == i)) EventReadValM[SEL_W-1:0] = sel_q[i];
      if (flag_hit && (32'(idx) == i)) begin
        EventReadValM[OF_BIT] = of_q[i];
`ifdef HPM_PRIV_FILTER_EN
        EventReadValM[MINH_BIT] = minh_q[i];
        EventReadValM[SINH_BIT] = sinh_q[i];
        EventReadValM[UINH_BIT] = uinh_q[i];
`endif
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, CSRWriteValM, CounterWrapM, MCOUNTINHIBIT_REGW,
                       PrivilegeModeW, privinh, UINH_BIT[0], SINH_BIT[0], MINH_BIT[0]};

endmodule

// File: tb/tb_hpm_event_ctrl.sv
// Directed bench for hpm_event_ctrl: a vector table on an RV64 instance plus
// hand sequences for async reset and the RV32 high-half CSRs.
module tb_hpm_event_ctrl;

`ifdef HPM_PRIV_FILTER_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk, reset, we, instret, clr;
  logic [11:0] adr;
  logic [63:0] wdata;
  logic [1:0]  priv;
  logic [31:0] src, wrap, inh;
  logic [31:0] ev64, ev32;
  logic [63:0] rd64;
  logic [31:0] rd32;
  logic        hit64, hit32, lcof64, lcof32;

  int checks = 0;
  int errors = 0;

  hpm_event_ctrl #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .CSRMWriteM(we), .CSRAdrM(adr), .CSRWriteValM(wdata),
    .PrivilegeModeW(priv), .EventSrcM(src), .InstrRetiredM(instret),
    .CounterWrapM(wrap), .MCOUNTINHIBIT_REGW(inh), .LCOFIClrM(clr),
    .CounterEventM(ev64), .EventReadValM(rd64), .EventCSRHitM(hit64),
    .LCOFIPendingM(lcof64)
  );

  hpm_event_ctrl #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .CSRMWriteM(we), .CSRAdrM(adr), .CSRWriteValM(wdata[31:0]),
    .PrivilegeModeW(priv), .EventSrcM(src), .InstrRetiredM(instret),
    .CounterWrapM(wrap), .MCOUNTINHIBIT_REGW(inh), .LCOFIClrM(clr),
    .CounterEventM(ev32), .EventReadValM(rd32), .EventCSRHitM(hit32),
    .LCOFIPendingM(lcof32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] adr;
    logic [63:0] wdata;
    logic [1:0]  priv;
    logic [31:0] src;
    logic        instret;
    logic [31:0] wrap;
    logic [31:0] inh;
    logic        clr;
    logic        hit;
    logic [63:0] rd;
    logic [31:0] ev;
    logic        lcof;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [63:0] d,
                              input logic [1:0] p, input logic [31:0] s, input logic ir,
                              input logic [31:0] wr, input logic [31:0] ih, input logic c,
                              input logic h, input logic [63:0] r, input logic [31:0] e,
                              input logic l);
    vec_t v;
    v.we = w; v.adr = a; v.wdata = d; v.priv = p; v.src = s; v.instret = ir;
    v.wrap = wr; v.inh = ih; v.clr = c; v.hit = h; v.rd = r; v.ev = e; v.lcof = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; adr = 12'h0; wdata = '0; priv = 2'd3; src = '0;
    instret = 1'b0; wrap = '0; inh = '0; clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    we = v.we; adr = v.adr; wdata = v.wdata; priv = v.priv; src = v.src;
    instret = v.instret; wrap = v.wrap; inh = v.inh; clr = v.clr;
    #1;
    check($sformatf("v%0d_hit", k), 64'(hit64), 64'(v.hit));
    check($sformatf("v%0d_rd", k), rd64, v.rd);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_ev", k), 64'(ev64), 64'(v.ev));
    check($sformatf("v%0d_lcof", k), 64'(lcof64), 64'(v.lcof));
  endtask

  localparam logic [63:0] OF  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] RD6 = PF ? 64'h4000_0000_0000_0009 : 64'h9;

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset state and async reset with everything active
    repeat (2) @(posedge clk);
    #1;
    check("rst_ev", 64'(ev64), 64'h0);
    check("rst_lcof", 64'(lcof64), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 3; n < 32; n++) begin
      @(negedge clk);
      we = 1'b1; adr = 12'(12'h320 + n); wdata = 64'd5;
    end
    @(negedge clk);
    we = 1'b0; adr = 12'h323; src = '1; instret = 1'b1; wrap = 32'h8;
    @(posedge clk);
    #1;
    check("busy_ev", 64'(ev64), 64'hFFFF_FFFD);
    check("busy_lcof", 64'(lcof64), 64'h1);
    wrap = '0;
    #2;
    reset = 1'b1;
    #1;
    check("async_ev", 64'(ev64), 64'h0);
    check("async_lcof", 64'(lcof64), 64'h0);
    check("async_rd", rd64, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ev1", 64'(ev64), 64'h5);
    @(posedge clk);
    #1;
    check("post_rst_ev2", 64'(ev64), 64'h5);
    idle_inputs();

    // Vector table on the RV64 instance
    vt.push_back(mk(1, 12'h323, 64'd7, 3, 0, 0, 0, 0, 0,          1, 0, 32'h1, 0));
    vt.push_back(mk(0, 12'h323, 0, 3, 32'h80, 0, 0, 0, 0,         1, 7, 32'h9, 0));
    vt.push_back(mk(0, 12'h323, 0, 3, 0, 0, 0, 0, 0,              1, 7, 32'h1, 0));
    vt.push_back(mk(0, 12'h323, 0, 3, 32'h40, 0, 0, 0, 0,         1, 7, 32'h1, 0));
    vt.push_back(mk(0, 12'h324, 0, 3, 32'h1, 0, 0, 0, 0,          1, 0, 32'h1, 0));
    vt.push_back(mk(1, 12'h324, 64'h4000_0000_0000_0009, 3, 0, 0, 0, 0, 0, 1, 0, 32'h1, 0));
    vt.push_back(mk(0, 12'h324, 0, 3, 32'h200, 0, 0, 0, 0,        1, RD6, PF ? 32'h1 : 32'h11, 0));
    vt.push_back(mk(0, 12'h324, 0, 0, 32'h200, 0, 0, 0, 0,        1, RD6, 32'h11, 0));
    vt.push_back(mk(0, 12'h324, 0, 0, 32'h200, 0, 0, 32'h10, 0,   1, RD6, 32'h1, 0));
    vt.push_back(mk(0, 12'h324, 0, 0, 0, 0, 0, 32'h1, 0,          1, RD6, 32'h0, 0));
    vt.push_back(mk(0, 12'h323, 0, 0, 0, 1, 0, 32'h4, 0,          1, 7, 32'h1, 0));
    vt.push_back(mk(0, 12'h323, 0, 0, 0, 1, 0, 0, 0,              1, 7, 32'h5, 0));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 32'h20, 0, 0,         1, 0, 32'h1, 1));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 0, 0, 0,              1, OF, 32'h1, 1));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 0, 0, 1,              1, OF, 32'h1, 0));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 32'h20, 0, 0,         1, OF, 32'h1, 0));
    vt.push_back(mk(1, 12'h325, 0, 0, 0, 0, 0, 0, 0,              1, OF, 32'h1, 0));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 32'h20, 0, 0,         1, 0, 32'h1, 1));
    vt.push_back(mk(0, 12'h325, 0, 0, 0, 0, 0, 0, 1,              1, OF, 32'h1, 0));
    vt.push_back(mk(1, 12'h326, 0, 0, 0, 0, 32'h40, 0, 1,         1, 0, 32'h1, 1));
    vt.push_back(mk(0, 12'h326, 0, 0, 0, 0, 0, 0, 0,              1, OF, 32'h1, 1));
    vt.push_back(mk(0, 12'h322, 0, 0, 0, 0, 0, 0, 1,              0, 0, 32'h1, 0));
    vt.push_back(mk(0, 12'h33F, 0, 0, 0, 0, 0, 0, 0,              1, 0, 32'h1, 0));
    vt.push_back(mk(1, 12'h723, 64'hF000_0000, 0, 0, 0, 0, 0, 0,  0, 0, 32'h1, 0));
    vt.push_back(mk(0, 12'h320, 0, 0, 0, 0, 32'h7, 0, 0,          0, 0, 32'h1, 0));
    vt.push_back(mk(0, 12'h33F, 0, 0, 0, 0, 32'h8000_0000, 0, 0,  1, 0, 32'h1, 1));
    vt.push_back(mk(0, 12'h33F, 0, 0, 0, 0, 0, 0, 1,              1, OF, 32'h1, 0));
    vt.push_back(mk(0, 12'h340, 0, 0, 0, 0, 0, 0, 0,              0, 0, 32'h1, 0));

    foreach (vt[k]) run_vec(vt[k], k);

    // RV32 high-half CSRs, decode holes and inhibit
    @(negedge clk);
    idle_inputs();
    we = 1'b1; adr = 12'h723; wdata = 64'hF000_0000;
    @(negedge clk);
    we = 1'b1; adr = 12'h323; wdata = 64'd3;
    @(negedge clk);
    we = 1'b0; adr = 12'h723;
    #1;
    check("rv32_h_hit", 64'(hit32), 64'h1);
    check("rv32_h_rd", 64'(rd32), PF ? 64'hF000_0000 : 64'h8000_0000);
    check("rv64_h_hit", 64'(hit64), 64'h0);
    check("rv64_h_rd", rd64, 64'h0);
    @(negedge clk);
    adr = 12'h323;
    #1;
    check("rv32_lo_hit", 64'(hit32), 64'h1);
    check("rv32_lo_rd", 64'(rd32), 64'h3);
    @(negedge clk);
    adr = 12'h322;
    #1;
    check("rv32_322_hit", 64'(hit32), 64'h0);
    check("rv32_322_rd", 64'(rd32), 64'h0);
    @(negedge clk);
    we = 1'b1; adr = 12'h723; wdata = 64'h0;
    @(negedge clk);
    we = 1'b0; src = 32'h8; inh = 32'h0;
    @(posedge clk);
    #1;
    check("rv32_ev_on", 64'(ev32), 64'h9);
    check("rv64_ev_on", 64'(ev64), 64'h9);
    @(negedge clk);
    inh = 32'h8;
    @(posedge clk);
    #1;
    check("rv32_ev_inh", 64'(ev32), 64'h1);
    check("rv64_ev_inh", 64'(ev64), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpm_event_ctrl.md
Name: hpm_event_ctrl

Overview:
- Configures and sequences the hardware performance counter bank.
- Holds the mhpmevent3..31 CSRs (event select, privilege inhibit, overflow flag).
- Steers one of NUM_EVENTS raw event sources to each programmable counter through a registered event pipeline.
- Tracks counter wrap-around and raises the local counter-overflow interrupt pending bit (LCOFIP) for the trap logic.

Parameters:
- XLEN, 64, CSR width; 32 or 64.
- COUNTERS, 32, number of counters including fixed counters 0..2; range 3..32.
- NUM_EVENTS, 32, raw event source lines; source 0 is hard-wired "no event".
- SEL_W, 5, width of the event select field; must be at least clog2(NUM_EVENTS).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- CSRMWriteM  in  1  machine CSR write strobe, M stage
- CSRAdrM  in  12  CSR address
- CSRWriteValM  in  XLEN  CSR write data
- PrivilegeModeW  in  2  current privilege mode (M=3, S=1, U=0)
- EventSrcM  in  NUM_EVENTS  raw per-cycle event pulses; bit 0 ignored
- InstrRetiredM  in  1  instruction retired this cycle
- CounterWrapM  in  COUNTERS  counter i wrapped from all-ones to 0 this cycle
- MCOUNTINHIBIT_REGW  in  32  per-counter inhibit
- LCOFIClrM  in  1  software clear of LCOFIP (mip write with bit 13 = 0)
- CounterEventM  out  COUNTERS  increment enables to the counter bank
- EventReadValM  out  XLEN  read data for mhpmevent / mhpmeventh
- EventCSRHitM  out  1  CSRAdrM decodes to an implemented event CSR
- LCOFIPendingM  out  1  LCOFIP, to mip

Behaviour:
Register map:
- mhpmeventN at 0x320+N, for N = 3..COUNTERS-1.
- mhpmeventhN at 0x720+N, only when XLEN=32.
- Any other address, including N = 0..2: EventCSRHitM = 0, EventReadValM = 0.

Field layout (XLEN=64):
- bit 63 OF, bit 62 MINH, bit 61 SINH, bit 60 UINH.
- [SEL_W-1:0] SEL.
- All other bits read as 0; writes to them are ignored.

Field layout (XLEN=32):
- OF/MINH/SINH/UINH sit in mhpmeventh bits 31..28.
- SEL sits in mhpmevent [SEL_W-1:0].

SEL handling:
- SEL >= NUM_EVENTS is stored as written but selects no event.

Reset (asynchronous):
- All event registers = 0.
- CounterEventM = 0, LCOFIPendingM = 0.

Event pipeline (1-cycle latency, registered):
- CounterEventM[0](t+1) = ~MCOUNTINHIBIT_REGW[0].
- CounterEventM[1] = 0, always.
- CounterEventM[2](t+1) = InstrRetiredM(t) & ~MCOUNTINHIBIT_REGW[2](t).
- CounterEventM[i](t+1), i >= 3 = EventSrcM[SEL_i](t) & (SEL_i != 0) & ~MCOUNTINHIBIT_REGW[i](t) & ~privinh_i(t).
- privinh_i = (Priv==M & MINH) | (Priv==S & SINH) | (Priv==U & UINH).

Write timing:
- A write in cycle t takes effect on events sampled in cycle t+1.

Overflow:
- Per counter i >= 3: OF_next = (write ? wdata.OF : OF) | CounterWrapM[i]. The hardware set wins over a software clear in the same cycle.
- LCOFIP set when CounterWrapM[i] & ~OF_i (pre-write value) for any i >= 3.
- LCOFIP clear when LCOFIClrM.
- Set and clear in the same cycle: set wins.
- LCOFIPendingM is registered and is a level.
- A wrap while OF is already 1 does not re-set LCOFIP after software has cleared it.
- Wraps on counters 0..2 are ignored; they have no OF bit.

Reads:
- Combinational from current register state; a same-cycle write is not visible.

Optional Feature:
- Macro: HPM_PRIV_FILTER_EN.
- Defined: MINH/SINH/UINH implemented as above.
- Undefined: the three bits read 0, writes to them are ignored, and privinh_i = 0. OF, SEL and LCOFIP are unaffected.

Test Plan:
1. Reset mid-count, with EventSrcM all ones and all SEL = 5 -> outputs and registers read 0 immediately (no clock edge needed); after deassert, CounterEventM = 0x0000_0005 in cycle 2.
2. Write mhpmevent3 = 7, pulse EventSrcM[7] at cycle t -> CounterEventM[3] = 1 at t+1 only. Pulse EventSrcM[6] -> no increment. SEL = 0 with EventSrcM[0] = 1 -> no increment.
3. SEL4 = 9 with MINH = 1: PrivilegeModeW = 3 and EventSrcM[9] = 1 -> CounterEventM[4] = 0; PrivilegeModeW = 0 -> 1. With HPM_PRIV_FILTER_EN undefined: both 1, and mhpmevent4 reads bit 62 = 0.
4. CounterWrapM[5] = 1 -> next cycle mhpmevent5 OF = 1 and LCOFIPendingM = 1. LCOFIClrM -> 0. Second wrap on counter 5 -> LCOFIPendingM stays 0. Write OF = 0, then wrap -> 1.
5. Same cycle: write mhpmevent6 with OF = 0, CounterWrapM[6] = 1, LCOFIClrM = 1 (OF6 initially 0) -> OF6 = 1, LCOFIPendingM = 1.
6. XLEN=32: write 0xF000_0000 to 0x723 and 3 to 0x323 -> reads 0xF000_0000 and 0x0000_0003. Access to 0x322 -> EventCSRHitM = 0 and read value 0. MCOUNTINHIBIT_REGW[3] = 1 -> CounterEventM[3] = 0.
